// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared opcode, register and state definitions for the MIPS32 issue guard
package mips32_pkg;

    localparam int REG_W = 5;

    // Filler slot: OR R20,R20,R20. R20 is reserved, so the write is harmless.
    localparam logic [31:0] MIPS32_NOP = 32'h0e94a000;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_SLT   = 6'h04;
    localparam logic [5:0] OP_MUL   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h08;
    localparam logic [5:0] OP_SW    = 6'h09;
    localparam logic [5:0] OP_ADDI  = 6'h0a;
    localparam logic [5:0] OP_SUBI  = 6'h0b;
    localparam logic [5:0] OP_SLTI  = 6'h0c;
    localparam logic [5:0] OP_BNEQZ = 6'h0d;
    localparam logic [5:0] OP_BEQZ  = 6'h0e;
    localparam logic [5:0] OP_HLT   = 6'h3f;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    function automatic logic is_rtype(input logic [5:0] op);
        return op <= OP_MUL;
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQZ) || (op == OP_BNEQZ);
    endfunction

endpackage

// File: rtl/mips32_reg_use_decode.sv
// rtl/mips32_reg_use_decode.sv - maps an instruction word to its destination and source registers
module mips32_reg_use_decode
    import mips32_pkg::*;
(
    input  logic [31:0]      instr_i,
    output logic [REG_W-1:0] dest_o,
    output logic             dest_valid_o,
    output logic [REG_W-1:0] src1_o,
    output logic             src1_valid_o,
    output logic [REG_W-1:0] src2_o,
    output logic             src2_valid_o
);

    logic [5:0]       op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;

    assign op = instr_i[31:26];
    assign rs = instr_i[25:21];
    assign rt = instr_i[20:16];
    assign rd = instr_i[15:11];

    // Register usage by opcode class; R0 is neither a real producer nor a real dependency.
    always_comb begin
        dest_o       = '0;
        dest_valid_o = 1'b0;
        src1_o       = rs;
        src1_valid_o = 1'b0;
        src2_o       = rt;
        src2_valid_o = 1'b0;
        if (is_rtype(op)) begin
            dest_o       = rd;
            dest_valid_o = 1'b1;
            src1_valid_o = 1'b1;
            src2_valid_o = 1'b1;
        end else begin
            case (op)
                OP_LW, OP_ADDI, OP_SUBI, OP_SLTI: begin
                    dest_o       = rt;
                    dest_valid_o = 1'b1;
                    src1_valid_o = 1'b1;
                end
                OP_SW: begin
                    src1_valid_o = 1'b1;
                    src2_valid_o = 1'b1;
                end
                OP_BNEQZ, OP_BEQZ: begin
                    src1_valid_o = 1'b1;
                end
                default: begin
                end
            endcase
        end
        if (dest_o == '0) dest_valid_o = 1'b0;
        if (src1_o == '0) src1_valid_o = 1'b0;
        if (src2_o == '0) src2_valid_o = 1'b0;
    end

endmodule

// File: rtl/mips32_hazard_guard.sv
// rtl/mips32_hazard_guard.sv - RAW/halt issue interlock; MIPS32_BRANCH_BUBBLE_EN adds post-branch bubbles
module mips32_hazard_guard
    import mips32_pkg::*;
#(
    parameter int HAZ_DEPTH  = 2,
    parameter int BR_BUBBLES = 2
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic        out_bubble,
    output logic        halted,
    output logic [15:0] bubble_count
);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic             out_bubble_q, out_bubble_d;
    logic [15:0]      bubble_count_q, bubble_count_d;
    logic [REG_W-1:0] hist_dest_q [HAZ_DEPTH];
    logic [REG_W-1:0] hist_dest_d [HAZ_DEPTH];
    logic [HAZ_DEPTH-1:0] hist_vld_q, hist_vld_d;

    logic [REG_W-1:0] dec_dest, dec_src1, dec_src2;
    logic             dec_dest_valid, dec_src1_valid, dec_src2_valid;
    logic             hazard;
    logic             br_pending;
    logic             accept;

    mips32_reg_use_decode u_decode (
        .instr_i      (in_instr),
        .dest_o       (dec_dest),
        .dest_valid_o (dec_dest_valid),
        .src1_o       (dec_src1),
        .src1_valid_o (dec_src1_valid),
        .src2_o       (dec_src2),
        .src2_valid_o (dec_src2_valid)
    );

`ifdef MIPS32_BRANCH_BUBBLE_EN
    logic [7:0] br_cnt_q, br_cnt_d;
    assign br_pending = (br_cnt_q != 8'd0);

    // Post-branch bubble counter: loaded when a branch issues, drained one per bubble slot.
    always_ff @(posedge clk1) begin
        if (rst) begin
            br_cnt_q <= 8'd0;
        end else begin
            br_cnt_q <= br_cnt_d;
        end
    end
`else
    logic unused_br_cfg;
    assign br_pending    = 1'b0;
    assign unused_br_cfg = (BR_BUBBLES != 0);
`endif

    // RAW check of the presented instruction against the most recently issued slots.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (hist_vld_q[i] &&
                ((dec_src1_valid && (dec_src1 == hist_dest_q[i])) ||
                 (dec_src2_valid && (dec_src2 == hist_dest_q[i])))) begin
                hazard = 1'b1;
            end
        end
    end

    assign in_ready = !rst && out_ready && (state_q == ST_RUN) && !hazard && !br_pending;
    assign accept   = in_valid && in_ready;

    // Slot sequencing: issue or bubble in RUN, retire HLT in DRAIN, idle in HALT.
    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_bubble_d   = out_bubble_q;
        bubble_count_d = bubble_count_q;
        hist_dest_d    = hist_dest_q;
        hist_vld_d     = hist_vld_q;
`ifdef MIPS32_BRANCH_BUBBLE_EN
        br_cnt_d       = br_cnt_q;
`endif
        if (out_ready) begin
            case (state_q)
                ST_RUN: begin
                    out_valid_d = 1'b1;
                    for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
                        hist_dest_d[i] = hist_dest_q[i-1];
                        hist_vld_d[i]  = hist_vld_q[i-1];
                    end
                    if (accept) begin
                        out_instr_d    = in_instr;
                        out_bubble_d   = 1'b0;
                        hist_dest_d[0] = dec_dest;
                        hist_vld_d[0]  = dec_dest_valid;
                        if (in_instr[31:26] == OP_HLT) state_d = ST_DRAIN;
`ifdef MIPS32_BRANCH_BUBBLE_EN
                        if (is_branch(in_instr[31:26])) br_cnt_d = 8'(BR_BUBBLES);
`endif
                    end else begin
                        // Filler's R20 write is deliberately kept out of history.
                        out_instr_d    = MIPS32_NOP;
                        out_bubble_d   = 1'b1;
                        hist_dest_d[0] = '0;
                        hist_vld_d[0]  = 1'b0;
                        if (bubble_count_q != 16'hFFFF) bubble_count_d = bubble_count_q + 16'd1;
`ifdef MIPS32_BRANCH_BUBBLE_EN
                        if (br_cnt_q != 8'd0) br_cnt_d = br_cnt_q - 8'd1;
`endif
                    end
                end
                ST_DRAIN: begin
                    out_valid_d = 1'b0;
                    state_d     = ST_HALT;
                end
                default: begin
                end
            endcase
        end
    end

    // State, output slot and history registers.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q        <= ST_RUN;
            out_valid_q    <= 1'b0;
            out_instr_q    <= MIPS32_NOP;
            out_bubble_q   <= 1'b0;
            bubble_count_q <= 16'd0;
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                hist_dest_q[i] <= '0;
            end
            hist_vld_q     <= '0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_bubble_q   <= out_bubble_d;
            bubble_count_q <= bubble_count_d;
            hist_dest_q    <= hist_dest_d;
            hist_vld_q     <= hist_vld_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_bubble   = out_bubble_q;
    assign halted       = (state_q == ST_HALT);
    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_mips32_hazard_guard.sv
// tb/tb_mips32_hazard_guard.sv - directed and randomized checks of the MIPS32 issue guard
module tb_mips32_hazard_guard;

    localparam int HAZ = 2;
`ifdef MIPS32_BRANCH_BUBBLE_EN
    localparam int EXP_BR = 2;
`else
    localparam int EXP_BR = 0;
`endif
    localparam logic [31:0] NOP = 32'h0e94a000;

    localparam logic [31:0] I_ADDI_R10 = 32'h280a00c8;
    localparam logic [31:0] I_LW_R3    = 32'h21430000;
    localparam logic [31:0] I_ADDI_R2  = 32'h28020001;
    localparam logic [31:0] I_MUL      = 32'h14431000;
    localparam logic [31:0] I_SUBI     = 32'h2c630001;
    localparam logic [31:0] I_BNEQZ    = 32'h3460fffc;
    localparam logic [31:0] I_HLT      = 32'hfc000000;
    localparam logic [31:0] I_ADDI_R0  = 32'h28000005;
    localparam logic [31:0] I_ADD_R1   = 32'h00000800;

    logic        clk1;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic        out_bubble;
    logic        halted;
    logic [15:0] bubble_count;

    int tests;
    int fails;

    // Reference: list of destinations of issued slots (-1 = none), plus slot contents.
    int          m_hist[$];
    int          m_state;
    bit          m_valid;
    logic [31:0] m_instr;
    bit          m_bubble;
    int          m_count;
    int          m_br;
    bit          m_accept;

    mips32_hazard_guard #(.HAZ_DEPTH(HAZ), .BR_BUBBLES(2)) dut (
        .clk1         (clk1),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_bubble   (out_bubble),
        .halted       (halted),
        .bubble_count (bubble_count)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int dest_of(input logic [31:0] ins);
        int op, d;
        op = int'(ins[31:26]);
        if (op <= 5) d = int'(ins[15:11]);
        else if (op == 8 || (op >= 10 && op <= 12)) d = int'(ins[20:16]);
        else d = 0;
        return (d == 0) ? -1 : d;
    endfunction

    function automatic bit reads_reg(input logic [31:0] ins, input int r);
        int op, rs, rt;
        op = int'(ins[31:26]);
        rs = int'(ins[25:21]);
        rt = int'(ins[20:16]);
        if (r <= 0) return 1'b0;
        if (op <= 5 || op == 9) return (rs == r) || (rt == r);
        if (op == 8 || (op >= 10 && op <= 14)) return rs == r;
        return 1'b0;
    endfunction

    function automatic bit m_hazard(input logic [31:0] ins);
        bit h;
        h = 1'b0;
        for (int k = 0; k < HAZ && k < m_hist.size(); k++) begin
            if (reads_reg(ins, m_hist[m_hist.size() - 1 - k])) h = 1'b1;
        end
        return h;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, out_valid, m_valid);
        chk({tag, ".out_instr"}, out_instr, m_instr);
        chk({tag, ".out_bubble"}, out_bubble, m_bubble);
        chk({tag, ".halted"}, halted, (m_state == 2));
        chk({tag, ".bubble_count"}, bubble_count, m_count);
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic ord);
        bit exp_rdy;
        @(negedge clk1);
        rst       = 1'b0;
        in_valid  = v;
        in_instr  = ins;
        out_ready = ord;
        #1;
        exp_rdy = ord && (m_state == 0) && !m_hazard(ins) && (m_br == 0);
        chk("in_ready", in_ready, exp_rdy);
        @(posedge clk1);
        m_accept = 1'b0;
        if (ord) begin
            if (m_state == 0) begin
                m_valid = 1'b1;
                if (v && exp_rdy) begin
                    m_instr  = ins;
                    m_bubble = 1'b0;
                    m_accept = 1'b1;
                    m_hist.push_back(dest_of(ins));
                    if (ins[31:26] == 6'h3f) m_state = 1;
                    if (ins[31:26] == 6'h0d || ins[31:26] == 6'h0e) m_br = EXP_BR;
                end else begin
                    m_instr  = NOP;
                    m_bubble = 1'b1;
                    m_hist.push_back(-1);
                    if (m_count < 65535) m_count++;
                    if (m_br > 0) m_br--;
                end
                if (m_hist.size() > 4) void'(m_hist.pop_front());
            end else if (m_state == 1) begin
                m_valid = 1'b0;
                m_state = 2;
            end
        end
        #1;
        check_outputs("slot");
    endtask

    task automatic do_reset(input logic v, input logic [31:0] ins);
        @(negedge clk1);
        rst       = 1'b1;
        in_valid  = v;
        in_instr  = ins;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        @(posedge clk1);
        m_hist.delete();
        m_state  = 0;
        m_valid  = 1'b0;
        m_instr  = NOP;
        m_bubble = 1'b0;
        m_count  = 0;
        m_br     = 0;
        #1;
        check_outputs("reset");
    endtask

    // Present one instruction until accepted; returns the DUT bubble delta.
    task automatic send(input logic [31:0] ins, output int nb);
        int start;
        bit acc;
        start = int'(bubble_count);
        acc   = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            step(1'b1, ins, 1'b1);
            acc = m_accept;
        end
        chk("send_accept", acc, 1'b1);
        nb = int'(bubble_count) - start;
    endtask

    initial begin
        int nb;
        logic [5:0]  ops [13];
        logic [31:0] ri;
        tests = 0;
        fails = 0;
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e};
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
        m_br      = 0;

        do_reset(1'b0, 32'h0);

        // ADDI R10 then dependent LW: exactly two bubbles.
        send(I_ADDI_R10, nb);
        chk("addi_first_no_bubble", nb, 0);
        send(I_LW_R3, nb);
        chk("lw_two_bubbles", nb, 2);
        chk("lw_total_count", bubble_count, 16'd2);

        // Independent pair issues back to back.
        send(I_ADDI_R10, nb);
        send(I_ADDI_R2, nb);
        chk("independent_no_bubble", nb, 0);

        // Clear history, then MUL / SUBI / BNEQZ chain.
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        send(I_MUL, nb);
        chk("mul_no_bubble", nb, 0);
        send(I_SUBI, nb);
        chk("subi_no_bubble", nb, 0);
        send(I_BNEQZ, nb);
        chk("bneqz_two_bubbles", nb, 2);
        send(I_ADDI_R2, nb);
        chk("post_branch_bubbles", nb, EXP_BR);

        // Freeze mid-stall: out_ready low for 5 cycles.
        send(I_ADDI_R10, nb);
        step(1'b1, I_LW_R3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, I_LW_R3, 1'b0);
            chk("freeze_bubble_held", out_bubble, 1'b1);
        end
        send(I_LW_R3, nb);
        chk("freeze_resume_one_more", nb, 1);

        // Writes to R0 never create a dependency.
        send(I_ADDI_R0, nb);
        send(I_ADD_R1, nb);
        chk("r0_no_bubble", nb, 0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 300; i++) begin
            ri = {ops[$urandom_range(0, 12)], 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 16'($urandom)};
            ri[15:11] = 5'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, ri, $urandom_range(0, 4) != 0);
        end

        // HLT drains once, then the guard idles.
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        send(I_HLT, nb);
        chk("hlt_issued", out_instr, I_HLT);
        step(1'b1, I_ADDI_R2, 1'b1);
        chk("halt_valid_low", out_valid, 1'b0);
        chk("halt_flag", halted, 1'b1);
        step(1'b1, I_ADDI_R2, 1'b1);
        chk("halt_no_ready", in_ready, 1'b0);

        // Reset pulse restores everything.
        do_reset(1'b1, I_ADDI_R2);
        send(I_ADDI_R10, nb);
        chk("post_reset_issue", out_instr, I_ADDI_R10);

        // Reset in the middle of a stall drops the pending instruction.
        step(1'b1, I_LW_R3, 1'b1);
        do_reset(1'b1, I_LW_R3);
        step(1'b1, I_LW_R3, 1'b0);
        chk("stall_reset_empty", out_valid, 1'b0);
        send(I_LW_R3, nb);
        chk("stall_reset_no_bubble", nb, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
